// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file constants and types.
//   REG_ADDR_W / REG_DATA_W : architectural register address / data widths
//   REG_COUNT               : number of architectural integer registers
//   REG_ZERO                : address of the hardwired-zero register x0
//   wb_src_t                : write-back data mux source select encodings
// Configuration macro: REGFILE_BYPASS_EN (consumed by reg_file and
// reg_file_scoreboard, not by this package).
package reg_file_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int REG_COUNT  = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

   // Source select of the write-back data mux that feeds rd_data.
   typedef enum logic [1:0] {
      WB_SRC_ALU = 2'd0,
      WB_SRC_MEM = 2'd1,
      WB_SRC_PC4 = 2'd2,
      WB_SRC_IMM = 2'd3
   } wb_src_t;

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: decode/write-back side bus of the integer register file.
//   rs1_addr/rs2_addr -> rs1_data/rs2_data : combinational operand reads
//   rd_wen/rd_addr/rd_data                : write-back port
//   issue_*                               : instruction presented by decode
//   hazard                                : operand pending, decode holds
// Modports: master = pipeline (decode + write-back), slave = register file.
interface reg_file_if;
   import reg_file_pkg::*;

   reg_addr_t rs1_addr;
   reg_addr_t rs2_addr;
   reg_data_t rs1_data;
   reg_data_t rs2_data;

   logic      rd_wen;
   reg_addr_t rd_addr;
   reg_data_t rd_data;

   logic      issue_valid;
   logic      issue_rs1_used;
   logic      issue_rs2_used;
   logic      issue_rd_wen;
   reg_addr_t issue_rd;
   logic      hazard;

   modport master (
      output rs1_addr, rs2_addr,
      input  rs1_data, rs2_data,
      output rd_wen, rd_addr, rd_data,
      output issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_wen, issue_rd,
      input  hazard
   );

   modport slave (
      input  rs1_addr, rs2_addr,
      output rs1_data, rs2_data,
      input  rd_wen, rd_addr, rd_data,
      input  issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_wen, issue_rd,
      output hazard
   );

endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: pending-write scoreboard and read-after-write hazard.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rs1_addr, rs2_addr  : operand addresses of the issuing instruction
//   rd_wen, rd_addr     : write-back port (clears the pending bit)
//   issue_*             : issuing instruction (sets the pending bit if accepted)
//   hazard              : an operand in use is still pending
// Macro REGFILE_BYPASS_EN: a register written back this cycle is not pending.
module reg_file_scoreboard
   import reg_file_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  reg_addr_t rs1_addr,
   input  reg_addr_t rs2_addr,
   input  logic      rd_wen,
   input  reg_addr_t rd_addr,
   input  logic      issue_valid,
   input  logic      issue_rs1_used,
   input  logic      issue_rs2_used,
   input  logic      issue_rd_wen,
   input  reg_addr_t issue_rd,
   output logic      hazard
);

   logic [REG_COUNT-1:0] busy_reg;
   logic [REG_COUNT-1:0] busy_next;
   logic [REG_COUNT-1:0] pend;
   logic                 issue_accept;

   // Only a non-stalled issue may claim its destination.
   assign issue_accept = issue_valid & ~hazard;

   genvar gi;
   generate
      for (gi = 0; gi < REG_COUNT; gi++) begin : g_busy
         if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
            assign pend[gi]      = 1'b0;
         end else begin : g_reg
            logic set_hit;
            logic clr_hit;
            assign set_hit = issue_accept & issue_rd_wen & (issue_rd == reg_addr_t'(gi));
            assign clr_hit = rd_wen & (rd_addr == reg_addr_t'(gi));
            // A same-cycle issue is a newer producer than the retiring one.
            assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
`ifdef REGFILE_BYPASS_EN
            // Forwarded on the read port this cycle, so nothing to wait for.
            assign pend[gi] = busy_reg[gi] & ~clr_hit;
`else
            assign pend[gi] = busy_reg[gi];
`endif
         end
      end
   endgenerate

   assign hazard = (issue_rs1_used & pend[rs1_addr]) | (issue_rs2_used & pend[rs2_addr]);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

endmodule

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit integer register file with pending-write scoreboard.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears registers and scoreboard)
//   bus : reg_file_if.slave -- two combinational read ports, one write-back
//         port, decode issue information and the hazard stall output
// x0 is not stored: it reads as zero and writes to it are dropped.
// Macro REGFILE_BYPASS_EN: forward the write-back value to a read port that
// addresses the register being written in the same cycle.
module reg_file
   import reg_file_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   reg_file_if.slave bus
);

   reg_data_t regs_reg [1:REG_COUNT-1];
   reg_data_t view     [REG_COUNT];

   // Storage. Every register has a reset, so this maps to flops rather than RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < REG_COUNT; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (bus.rd_wen && bus.rd_addr != REG_ZERO) begin
         regs_reg[bus.rd_addr] <= bus.rd_data;
      end
   end

   // Full 32-entry read view with x0 tied to zero, so read muxes never index
   // outside the stored range.
   genvar gi;
   generate
      for (gi = 0; gi < REG_COUNT; gi++) begin : g_view
         if (gi == 0) begin : g_zero
            assign view[gi] = '0;
         end else begin : g_reg
            assign view[gi] = regs_reg[gi];
         end
      end
   endgenerate

`ifdef REGFILE_BYPASS_EN
   logic wb_live;
   assign wb_live = bus.rd_wen && (bus.rd_addr != REG_ZERO);
   assign bus.rs1_data = (wb_live && bus.rd_addr == bus.rs1_addr) ? bus.rd_data : view[bus.rs1_addr];
   assign bus.rs2_data = (wb_live && bus.rd_addr == bus.rs2_addr) ? bus.rd_data : view[bus.rs2_addr];
`else
   assign bus.rs1_data = view[bus.rs1_addr];
   assign bus.rs2_data = view[bus.rs2_addr];
`endif

   reg_file_scoreboard u_scoreboard (
      .clk            (clk),
      .rst            (rst),
      .rs1_addr       (bus.rs1_addr),
      .rs2_addr       (bus.rs2_addr),
      .rd_wen         (bus.rd_wen),
      .rd_addr        (bus.rd_addr),
      .issue_valid    (bus.issue_valid),
      .issue_rs1_used (bus.issue_rs1_used),
      .issue_rs2_used (bus.issue_rs2_used),
      .issue_rd_wen   (bus.issue_rd_wen),
      .issue_rd       (bus.issue_rd),
      .hazard         (bus.hazard)
   );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed, table-driven bench for reg_file. Works with or
// without REGFILE_BYPASS_EN; expected values follow the macro.
module tb_reg_file;
   import reg_file_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic rst;

   reg_file_if bus ();

   reg_file dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string     name;
      logic      rst;
      reg_addr_t rs1;
      reg_addr_t rs2;
      logic      wen;
      reg_addr_t waddr;
      reg_data_t wdata;
      logic      iv;
      logic      u1;
      logic      u2;
      logic      iwen;
      reg_addr_t ird;
      reg_data_t e1;
      reg_data_t e2;
      logic      eh;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string n, logic r, reg_addr_t a1, reg_addr_t a2,
                               logic w, reg_addr_t wa, reg_data_t wd,
                               logic iv, logic u1, logic u2, logic iw, reg_addr_t ird,
                               reg_data_t e1, reg_data_t e2, logic eh);
      vec_t v;
      v.name = n; v.rst = r; v.rs1 = a1; v.rs2 = a2;
      v.wen = w; v.waddr = wa; v.wdata = wd;
      v.iv = iv; v.u1 = u1; v.u2 = u2; v.iwen = iw; v.ird = ird;
      v.e1 = e1; v.e2 = e2; v.eh = eh;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.rs1_addr = '0; bus.rs2_addr = '0;
      bus.rd_wen = 1'b0; bus.rd_addr = '0; bus.rd_data = '0;
      bus.issue_valid = 1'b0; bus.issue_rs1_used = 1'b0; bus.issue_rs2_used = 1'b0;
      bus.issue_rd_wen = 1'b0; bus.issue_rd = '0;
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state: every address reads zero, no hazard.
      for (int a = 0; a < 32; a++) begin
         @(posedge clk); #1;
         bus.rs1_addr = reg_addr_t'(a);
         bus.rs2_addr = reg_addr_t'(31 - a);
         bus.issue_valid = 1'b1; bus.issue_rs1_used = 1'b1; bus.issue_rs2_used = 1'b1;
         @(negedge clk);
         check($sformatf("reset_rs1_x%0d", a), bus.rs1_data, 32'h0);
         check($sformatf("reset_rs2_x%0d", 31 - a), bus.rs2_data, 32'h0);
         check($sformatf("reset_hazard_%0d", a), {31'b0, bus.hazard}, 32'h0);
         $display("reset read x%0d/x%0d -> %h %h haz=%b", a, 31 - a, bus.rs1_data, bus.rs2_data, bus.hazard);
      end

      //           name          rst rs1 rs2 wen wa  wdata           iv u1 u2 iw ird  exp_rs1                          exp_rs2        exp_haz
      vecs.push_back(mk("wr_x5",      0, 5,  0, 1, 5,  32'hDEADBEEF, 0, 0, 0, 0, 0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 0));
      vecs.push_back(mk("rd_x5_wr_x0",0, 5,  0, 1, 0,  32'h00001234, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0));
      vecs.push_back(mk("rd_x0",      0, 0,  5, 0, 0,  32'h0,        0, 0, 0, 0, 0, 32'h0, 32'hDEADBEEF, 0));
      vecs.push_back(mk("wr_rd_x7",   0, 7,  7, 1, 7,  32'hA5A5A5A5, 0, 0, 0, 0, 0, BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0, 0));
      vecs.push_back(mk("rewr_x7",    0, 7,  5, 1, 7,  32'h11111111, 0, 0, 0, 0, 0, BYP ? 32'h11111111 : 32'hA5A5A5A5, 32'hDEADBEEF, 0));
      vecs.push_back(mk("iss_rd_x3",  0, 3,  0, 0, 0,  32'h0,        1, 0, 0, 1, 3, 32'h0, 32'h0, 0));
      vecs.push_back(mk("raw_x3",     0, 3,  0, 0, 0,  32'h0,        1, 1, 0, 1, 10, 32'h0, 32'h0, 1));
      vecs.push_back(mk("stall_nobusy",0,3, 10, 0, 0,  32'h0,        1, 0, 1, 0, 0, 32'h0, 32'h0, 0));
      vecs.push_back(mk("wb_x3",      0, 3,  0, 1, 3,  32'h00000033, 1, 1, 0, 0, 0, BYP ? 32'h33 : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1));
      vecs.push_back(mk("after_wb_x3",0, 3,  0, 0, 0,  32'h0,        1, 1, 0, 0, 0, 32'h00000033, 32'h0, 0));
      vecs.push_back(mk("iss_wb_x9",  0, 9,  0, 1, 9,  32'h00000099, 1, 0, 0, 1, 9, BYP ? 32'h99 : 32'h0, 32'h0, 0));
      vecs.push_back(mk("x9_still_busy",0,0, 9, 0, 0,  32'h0,        1, 0, 1, 0, 0, 32'h0, 32'h00000099, 1));
      vecs.push_back(mk("wb_x9",      0, 0,  9, 1, 9,  32'h0000009A, 1, 0, 1, 0, 0, 32'h0, BYP ? 32'h9A : 32'h99, BYP ? 1'b0 : 1'b1));
      vecs.push_back(mk("after_wb_x9",0, 0,  9, 0, 0,  32'h0,        1, 0, 1, 0, 0, 32'h0, 32'h0000009A, 0));
      vecs.push_back(mk("iss_x12",    0, 12, 0, 0, 0,  32'h0,        1, 0, 0, 1, 12, 32'h0, 32'h0, 0));
      vecs.push_back(mk("waw_x12",    0, 12, 0, 0, 0,  32'h0,        1, 0, 0, 1, 12, 32'h0, 32'h0, 0));
      vecs.push_back(mk("wb_x12",     0, 12, 0, 1, 12, 32'h0000000C, 1, 1, 0, 0, 0, BYP ? 32'hC : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1));
      vecs.push_back(mk("after_x12",  0, 12, 0, 0, 0,  32'h0,        1, 1, 0, 0, 0, 32'h0000000C, 32'h0, 0));
      vecs.push_back(mk("iss_x4",     0, 4,  0, 0, 0,  32'h0,        1, 0, 0, 1, 4, 32'h0, 32'h0, 0));
      vecs.push_back(mk("rst_wb_x4",  1, 4,  5, 1, 4,  32'h00000044, 1, 1, 0, 1, 6, BYP ? 32'h44 : 32'h0, 32'hDEADBEEF, BYP ? 1'b0 : 1'b1));
      vecs.push_back(mk("post_rst",   0, 4,  6, 0, 0,  32'h0,        1, 1, 1, 0, 0, 32'h0, 32'h0, 0));
      vecs.push_back(mk("post_rst_rd",0, 5,  7, 0, 0,  32'h0,        1, 1, 1, 0, 0, 32'h0, 32'h0, 0));
      vecs.push_back(mk("iss_rd_x0",  0, 0,  0, 0, 0,  32'h0,        1, 0, 0, 1, 0, 32'h0, 32'h0, 0));
      vecs.push_back(mk("x0_never_busy",0,0, 0, 0, 0,  32'h0,        1, 1, 1, 0, 0, 32'h0, 32'h0, 0));

      foreach (vecs[k]) begin
         @(posedge clk); #1;
         rst                = vecs[k].rst;
         bus.rs1_addr       = vecs[k].rs1;
         bus.rs2_addr       = vecs[k].rs2;
         bus.rd_wen         = vecs[k].wen;
         bus.rd_addr        = vecs[k].waddr;
         bus.rd_data        = vecs[k].wdata;
         bus.issue_valid    = vecs[k].iv;
         bus.issue_rs1_used = vecs[k].u1;
         bus.issue_rs2_used = vecs[k].u2;
         bus.issue_rd_wen   = vecs[k].iwen;
         bus.issue_rd       = vecs[k].ird;
         @(negedge clk);
         check({vecs[k].name, "_rs1"}, bus.rs1_data, vecs[k].e1);
         check({vecs[k].name, "_rs2"}, bus.rs2_data, vecs[k].e2);
         check({vecs[k].name, "_hazard"}, {31'b0, bus.hazard}, {31'b0, vecs[k].eh});
         $display("vec %0d %s: rs1=%h rs2=%h hazard=%b", k, vecs[k].name, bus.rs1_data, bus.rs2_data, bus.hazard);
      end

      // Fill every register with a distinct pattern, then read all back.
      @(posedge clk); #1;
      rst = 1'b0;
      drive_idle();
      for (int a = 0; a < 32; a++) begin
         bus.rd_wen  = 1'b1;
         bus.rd_addr = reg_addr_t'(a);
         bus.rd_data = 32'h01010101 * a + 32'h10000000;
         @(posedge clk); #1;
         $display("fill x%0d <- %h", a, bus.rd_data);
      end
      bus.rd_wen = 1'b0;
      for (int a = 0; a < 32; a++) begin
         logic [31:0] e1;
         logic [31:0] e2;
         bus.rs1_addr = reg_addr_t'(a);
         bus.rs2_addr = reg_addr_t'(a ^ 1);
         e1 = (a == 0) ? 32'h0 : 32'h01010101 * a + 32'h10000000;
         e2 = ((a ^ 1) == 0) ? 32'h0 : 32'h01010101 * (a ^ 1) + 32'h10000000;
         @(negedge clk);
         check($sformatf("fill_rs1_x%0d", a), bus.rs1_data, e1);
         check($sformatf("fill_rs2_x%0d", a ^ 1), bus.rs2_data, e2);
         $display("readback x%0d=%h x%0d=%h", a, bus.rs1_data, a ^ 1, bus.rs2_data);
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
